// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter for the shared FIFO write port; grant is taken 1 cycle after valid, then 1 word/cycle.
// Backpressure: w_full combinationally drops req_ready and w_en; a MAX_BURST watchdog force-releases runaway packets.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 32,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 16,
    localparam int IDW      = $clog2(NREQ),
    localparam int BCW      = $clog2(MAX_BURST + 1)
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  w_en,
    output logic [WIDTH-1:0]      w_data,
    input  logic                  w_full,
    output logic                  busy,
    output logic [IDW-1:0]        grant_id,
    input  logic                  err_clr,
    output logic                  err_burst
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state, state_nxt;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  sel_idx;
    logic [IDW-1:0]  cand;
    logic [IDW-1:0]  ptr_after;
    logic [BCW-1:0]  beat_cnt;
    logic            sel_found;
    logic            accept;
    logic            release_pkt;
    logic            force_rel;

    // First valid source at or above rr_ptr, wrapping explicitly so non-power-of-two NREQ works.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = rr_ptr;
        cand      = rr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!sel_found && req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
            cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + IDW'(1);
        end
    end

    assign ptr_after = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

    always_comb begin
        state_nxt   = state;
        req_ready   = '0;
        w_en        = 1'b0;
        busy        = 1'b0;
        accept      = 1'b0;
        release_pkt = 1'b0;
        force_rel   = 1'b0;
        w_data      = req_data[int'(grant_id)*WIDTH +: WIDTH];
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_nxt = BURST;
                end
            end
            BURST: begin
                busy                = 1'b1;
                req_ready[grant_id] = !w_full;
                w_en                = req_valid[grant_id] & !w_full;
                accept              = w_en;
                if (accept) begin
                    if (req_last[grant_id]) begin
                        release_pkt = 1'b1;
                    end else if (beat_cnt == BCW'(MAX_BURST - 1)) begin
                        release_pkt = 1'b1;
                        force_rel   = 1'b1;
                    end
                end
                if (release_pkt) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            rr_ptr    <= '0;
            grant_id  <= '0;
            beat_cnt  <= '0;
            err_burst <= 1'b0;
        end else begin
            if (state == IDLE && sel_found) begin
                grant_id <= sel_idx;
                beat_cnt <= '0;
            end
            // Clearing on release keeps beat_cnt below MAX_BURST.
            if (release_pkt) begin
                beat_cnt <= '0;
                rr_ptr   <= ptr_after;
            end else if (accept) begin
                beat_cnt <= beat_cnt + BCW'(1);
            end
            if (force_rel) begin
                err_burst <= 1'b1;
            end else if (err_clr) begin
                err_burst <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: queue-fed sources and a packet-level reference model of the arbiter.
module tb_fifo_wr_arbiter;
    localparam int WIDTH     = 32;
    localparam int NREQ      = 4;
    localparam int MAX_BURST = 16;
    localparam int IDW       = 2;

    logic                  wclk = 1'b0;
    logic                  wrst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_last;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  w_en;
    logic [WIDTH-1:0]      w_data;
    logic                  w_full;
    logic                  busy;
    logic [IDW-1:0]        grant_id;
    logic                  err_clr;
    logic                  err_burst;

    fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(req_ready), .w_en(w_en), .w_data(w_data),
        .w_full(w_full), .busy(busy), .grant_id(grant_id), .err_clr(err_clr),
        .err_burst(err_burst)
    );

    always #5 wclk = ~wclk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [WIDTH:0]  src_q[NREQ][$];
    logic [NREQ-1:0] src_en;

    bit m_busy, m_err;
    int m_gnt, m_cnt, m_ptr;

    logic [40:0]      exp_out, obs_out;
    logic             obs_wen, obs_err;
    logic [IDW-1:0]   obs_gnt;
    logic [NREQ-1:0]  obs_rdy;
    logic [WIDTH-1:0] obs_wd;

    task automatic model_reset();
        m_busy = 0; m_err = 0; m_gnt = 0; m_cnt = 0; m_ptr = 0;
    endtask

    task automatic flush_all();
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
    endtask

    task automatic push_pkt(input int src, input int len, input bit with_last);
        for (int j = 0; j < len; j++)
            src_q[src].push_back({with_last && (j == len - 1), $urandom()});
    endtask

    task automatic do_reset();
        wrst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0;
        w_full = 1'b0; err_clr = 1'b0;
        flush_all();
        model_reset();
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    // One clock: drive sources from their queues, sample the DUT, then advance the model.
    task automatic step(input logic full, input logic clr);
        logic [NREQ-1:0]  v, l, rdy;
        logic [WIDTH-1:0] d[NREQ];
        logic             ewen;
        bit               forced;
        @(negedge wclk);
        for (int i = 0; i < NREQ; i++) begin
            v[i] = src_en[i] && (src_q[i].size() > 0);
            l[i] = 1'b0;
            d[i] = '0;
            if (src_q[i].size() > 0) begin
                l[i] = src_q[i][0][WIDTH];
                d[i] = src_q[i][0][WIDTH-1:0];
            end
            req_data[i*WIDTH +: WIDTH] = d[i];
        end
        req_valid = v; req_last = l; w_full = full; err_clr = clr;
        #1;
        rdy = '0;
        if (m_busy && !full) rdy[m_gnt] = 1'b1;
        ewen    = m_busy && v[m_gnt] && !full;
        exp_out = {m_busy, ewen, rdy, IDW'(m_gnt), m_err, d[m_gnt]};
        obs_out = {busy, w_en, req_ready, grant_id, err_burst, w_data};
        obs_wen = w_en; obs_gnt = grant_id; obs_err = err_burst;
        obs_rdy = req_ready; obs_wd = w_data;
        @(posedge wclk);
        forced = 0;
        if (!m_busy) begin
            for (int o = 0; o < NREQ; o++) begin
                int s = (m_ptr + o) % NREQ;
                if (!m_busy && v[s]) begin
                    m_busy = 1; m_gnt = s; m_cnt = 0;
                end
            end
        end else if (ewen) begin
            void'(src_q[m_gnt].pop_front());
            m_cnt++;
            if (l[m_gnt] || m_cnt == MAX_BURST) begin
                forced = !l[m_gnt];
                m_busy = 0;
                m_ptr  = (m_gnt + 1) % NREQ;
            end
        end
        if (forced) m_err = 1;
        else if (clr) m_err = 0;
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] d0;
        wrst_n = 1'b0;
        d0 = $urandom();
        req_valid = '1; req_last = '1; w_full = 1'b0; err_clr = 1'b0;
        req_data = {$urandom(), $urandom(), $urandom(), d0};
        #3;
        n_cmp++;
        if ({busy, w_en, req_ready, grant_id, err_burst} !== 9'd0) begin
            n_bad++;
            $display("FAIL reset_ctl got %b need 0", {busy, w_en, req_ready, grant_id, err_burst});
        end
        n_cmp++;
        if (w_data !== d0) begin
            n_bad++;
            $display("FAIL reset_wdata got %h need %h", w_data, d0);
        end
        repeat (3) @(posedge wclk);
        #1;
        n_cmp++;
        if ({busy, w_en, req_ready} !== 6'd0) begin
            n_bad++;
            $display("FAIL reset_hold got %b need 0", {busy, w_en, req_ready});
        end
        do_reset();
    endtask

    task automatic test_single();
        logic [4:0]     wen_mask;
        logic [95:0]    words;
        logic [IDW-1:0] g1, gnext;
        bit             seen;
        src_en = '1;
        src_q[2].push_back({1'b0, 32'hA0});
        src_q[2].push_back({1'b0, 32'hA1});
        src_q[2].push_back({1'b1, 32'hA2});
        wen_mask = '0; words = '0; g1 = '0;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0);
            n_cmp++;
            if (obs_out !== exp_out) begin
                n_bad++;
                $display("FAIL single_cyc%0d got %h need %h", k, obs_out, exp_out);
            end
            if (obs_wen) begin
                wen_mask[k] = 1'b1;
                words = {words[63:0], obs_wd};
            end
            if (k == 1) g1 = obs_gnt;
        end
        n_cmp++;
        if (wen_mask !== 5'b01110) begin
            n_bad++;
            $display("FAIL single_wen_cycles got %b need 01110", wen_mask);
        end
        n_cmp++;
        if (words !== {32'hA0, 32'hA1, 32'hA2}) begin
            n_bad++;
            $display("FAIL single_words got %h need a0a1a2", words);
        end
        n_cmp++;
        if (g1 !== 2'd2) begin
            n_bad++;
            $display("FAIL single_grant got %0d need 2", g1);
        end
        // Pointer now sits at 3: source 3 must beat source 0.
        src_q[0].push_back({1'b1, 32'hB0});
        src_q[3].push_back({1'b1, 32'hB3});
        seen = 0; gnext = '0;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0);
            n_cmp++;
            if (obs_out !== exp_out) begin
                n_bad++;
                $display("FAIL single_ptr_cyc%0d got %h need %h", k, obs_out, exp_out);
            end
            if (obs_wen && !seen) begin
                seen = 1; gnext = obs_gnt;
            end
        end
        n_cmp++;
        if (!seen || gnext !== 2'd3) begin
            n_bad++;
            $display("FAIL single_rr_ptr got seen=%0d grant=%0d need grant 3", seen, gnext);
        end
    endtask

    task automatic test_round_robin();
        logic [9:0] gseq;
        int         nw, last_k, bad_gap;
        do_reset();
        src_en = '1;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++) push_pkt(i, 1, 1);
        gseq = '0; nw = 0; last_k = -1; bad_gap = 0;
        for (int k = 0; k < 18; k++) begin
            step(1'b0, 1'b0);
            n_cmp++;
            if (obs_out !== exp_out) begin
                n_bad++;
                $display("FAIL rr_cyc%0d got %h need %h", k, obs_out, exp_out);
            end
            if (obs_wen) begin
                if (nw < 5) gseq = {gseq[7:0], obs_gnt};
                if (last_k >= 0 && k - last_k != 2) bad_gap++;
                last_k = k;
                nw++;
            end
        end
        n_cmp++;
        if (gseq !== {2'd0, 2'd1, 2'd2, 2'd3, 2'd0}) begin
            n_bad++;
            $display("FAIL rr_order got %b need 0001101100", gseq);
        end
        n_cmp++;
        if (nw != 8 || bad_gap != 0) begin
            n_bad++;
            $display("FAIL rr_gap got writes=%0d bad_gaps=%0d need 8/0", nw, bad_gap);
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH:0]   pkt[$];
        logic [8:0]       wen_mask;
        logic [WIDTH-1:0] got[$];
        int               bad_words;
        push_pkt(0, 4, 1);
        pkt = src_q[0];
        wen_mask = '0;
        for (int k = 0; k < 9; k++) begin
            step((k >= 3 && k <= 5), 1'b0);
            n_cmp++;
            if (obs_out !== exp_out) begin
                n_bad++;
                $display("FAIL bp_cyc%0d got %h need %h", k, obs_out, exp_out);
            end
            if (obs_wen) begin
                wen_mask[k] = 1'b1;
                got.push_back(obs_wd);
            end
        end
        n_cmp++;
        if (wen_mask !== 9'b011000110) begin
            n_bad++;
            $display("FAIL bp_wen_cycles got %b need 011000110", wen_mask);
        end
        bad_words = (got.size() == 4) ? 0 : 1;
        for (int j = 0; j < 4 && j < got.size(); j++)
            if (got[j] !== pkt[j][WIDTH-1:0]) bad_words++;
        n_cmp++;
        if (bad_words != 0) begin
            n_bad++;
            $display("FAIL bp_words got %0d words with %0d errors need 4 exact", got.size(), bad_words);
        end
    endtask

    task automatic test_watchdog();
        int             n1;
        logic           err17;
        logic [IDW-1:0] g18;
        logic           pf;
        push_pkt(1, 20, 0);
        push_pkt(2, 1, 1);
        n1 = 0; err17 = 1'b0; g18 = '0;
        for (int k = 0; k < 19; k++) begin
            step(1'b0, 1'b0);
            n_cmp++;
            if (obs_out !== exp_out) begin
                n_bad++;
                $display("FAIL wd_cyc%0d got %h need %h", k, obs_out, exp_out);
            end
            if (obs_wen && obs_gnt == 2'd1) n1++;
            if (k == 17) err17 = obs_err;
            if (k == 18) g18 = obs_wen ? obs_gnt : 2'd0;
        end
        n_cmp++;
        if (n1 != MAX_BURST || err17 !== 1'b1) begin
            n_bad++;
            $display("FAIL wd_force got words=%0d err=%b need %0d/1", n1, err17, MAX_BURST);
        end
        n_cmp++;
        if (g18 !== 2'd2) begin
            n_bad++;
            $display("FAIL wd_next_grant got %0d need 2", g18);
        end
        src_q[1].delete();
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        n_cmp++;
        if (obs_err !== 1'b0) begin
            n_bad++;
            $display("FAIL wd_clear got %b need 0", obs_err);
        end
        // Second overflow with err_clr landing on the forcing word.
        push_pkt(0, MAX_BURST, 0);
        for (int k = 0; k < 19; k++) begin
            pf = m_busy && m_gnt == 0 && m_cnt == MAX_BURST - 1 && src_en[0] &&
                 src_q[0].size() > 0 && !src_q[0][0][WIDTH];
            step(1'b0, pf);
            n_cmp++;
            if (obs_out !== exp_out) begin
                n_bad++;
                $display("FAIL wd2_cyc%0d got %h need %h", k, obs_out, exp_out);
            end
        end
        n_cmp++;
        if (obs_err !== 1'b1) begin
            n_bad++;
            $display("FAIL wd_set_wins got %b need 1", obs_err);
        end
    endtask

    task automatic test_idle_hold();
        int hold_bad, first_r3;
        push_pkt(1, 4, 1);
        push_pkt(3, 1, 1);
        hold_bad = 0; first_r3 = -1;
        for (int k = 0; k < 18; k++) begin
            src_en[1] = !(k >= 3 && k <= 12);
            step(1'b0, 1'b0);
            n_cmp++;
            if (obs_out !== exp_out) begin
                n_bad++;
                $display("FAIL hold_cyc%0d got %h need %h", k, obs_out, exp_out);
            end
            if (k >= 3 && k <= 12 && (obs_wen || obs_gnt != 2'd1 || obs_rdy[3])) hold_bad++;
            if (obs_rdy[3] && first_r3 < 0) first_r3 = k;
        end
        src_en = '1;
        n_cmp++;
        if (hold_bad != 0 || first_r3 != 16) begin
            n_bad++;
            $display("FAIL hold_grant got bad=%0d first_ready3=%0d need 0/16", hold_bad, first_r3);
        end
    endtask

    task automatic test_reset_mid();
        bit             seen;
        logic [IDW-1:0] g;
        push_pkt(2, 1, 1);
        push_pkt(3, 4, 1);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0);
            n_cmp++;
            if (obs_out !== exp_out) begin
                n_bad++;
                $display("FAIL rstmid_cyc%0d got %h need %h", k, obs_out, exp_out);
            end
        end
        #2 wrst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, w_en, req_ready, err_burst} !== 7'd0) begin
            n_bad++;
            $display("FAIL rstmid_async got %b need 0", {busy, w_en, req_ready, err_burst});
        end
        model_reset();
        flush_all();
        push_pkt(1, 1, 1);
        push_pkt(3, 1, 1);
        req_valid = '0;
        @(negedge wclk);
        wrst_n = 1'b1;
        seen = 0; g = '0;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0);
            n_cmp++;
            if (obs_out !== exp_out) begin
                n_bad++;
                $display("FAIL rstmid_post%0d got %h need %h", k, obs_out, exp_out);
            end
            if (obs_wen && !seen) begin
                seen = 1; g = obs_gnt;
            end
        end
        n_cmp++;
        if (!seen || g !== 2'd1) begin
            n_bad++;
            $display("FAIL rstmid_first_grant got seen=%0d grant=%0d need 1", seen, g);
        end
    endtask

    task automatic test_random();
        int pending, k;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 5) == 0) push_pkt($urandom_range(0, NREQ - 1), 20, 0);
                else push_pkt($urandom_range(0, NREQ - 1), $urandom_range(1, 6), 1);
            end
            if ($urandom_range(0, 15) == 0) src_en[$urandom_range(0, NREQ - 1)] ^= 1'b1;
            step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
            n_cmp++;
            if (obs_out !== exp_out) begin
                n_bad++;
                $display("FAIL rand_cyc%0d got %h need %h", c, obs_out, exp_out);
            end
        end
        src_en = '1;
        for (int i = 0; i < NREQ; i++) push_pkt(i, 1, 1);
        pending = 1; k = 0;
        while (pending != 0 && k < 400) begin
            step(1'b0, 1'b0);
            n_cmp++;
            if (obs_out !== exp_out) begin
                n_bad++;
                $display("FAIL rand_drain%0d got %h need %h", k, obs_out, exp_out);
            end
            pending = m_busy;
            for (int i = 0; i < NREQ; i++) pending += src_q[i].size();
            k++;
        end
        n_cmp++;
        if (pending != 0) begin
            n_bad++;
            $display("FAIL rand_drain_timeout got %0d pending need 0", pending);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got no finish need finish");
        $fatal(1, "timeout");
    end

    initial begin
        src_en = '1;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_watchdog();
        test_idle_hold();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter that shares the single write port of the dual-clock FIFO among NREQ packet sources in the write (AXI GPIO) clock domain. It grants one requester at a time in round-robin order and holds the grant for a whole packet, delimited by `req_last`. It gates every write on the FIFO's `w_full`, so no word is dropped. A MAX_BURST watchdog forces release of a source that never asserts `last`.

## Interface
- WIDTH, 32, data word width; equals the FIFO WIDTH.
- NREQ, 4, number of requesters; must be ≥2.
- MAX_BURST, 16, maximum words per packet before forced release; must be ≥1.
- wclk  in  1  write-domain clock; the only clock of this block.
- wrst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-source word valid.
- req_last  in  NREQ  per-source last-word-of-packet flag; qualified by valid.
- req_data  in  NREQ*WIDTH  flattened payloads; source i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  per-source accept; a word transfers when valid and ready are both high.
- w_en  out  1  FIFO write enable.
- w_data  out  WIDTH  FIFO write data.
- w_full  in  1  FIFO full flag; it is combinational on the FIFO side.
- busy  out  1  high while in state BURST.
- grant_id  out  $clog2(NREQ)  index of the current or most recent grant.
- err_clr  in  1  clears err_burst.
- err_burst  out  1  sticky flag: a packet was force-terminated by MAX_BURST.

## Operation
- **State machine**, two states, IDLE and BURST.
- **IDLE**
  - `req_ready` is all zero.
  - If any `req_valid` is high, select the first valid source searching from `rr_ptr` upward, modulo NREQ.
  - Register the selection into `grant_id`, clear `beat_cnt`, and go to BURST.
  - If no source is valid, stay in IDLE.
- **BURST**
  - `req_ready[grant_id] = !w_full`; all other ready bits are 0.
  - `w_en = req_valid[grant_id] & !w_full`.
  - `w_data = req_data[grant_id]` at all times, including when `w_en` is low.
  - An accepted word is one with `w_en` high. Each accepted word increments `beat_cnt`.
  - Accepted word with `req_last` high: go to IDLE, and set `rr_ptr = grant_id + 1`, wrapping NREQ-1 → 0.
  - Accepted word without `req_last` where `beat_cnt + 1 == MAX_BURST`: forced release. Go to IDLE, update `rr_ptr` as above, and set `err_burst`.
  - `req_valid[grant_id]` low: hold the grant indefinitely with no transfer. The watchdog counts words only, not cycles.
- **Requester rules**
  - A requester holds data and last stable while valid is high and ready is low.
  - Valid and ready of non-granted sources are ignored; those sources simply wait.
- **Width rules**
  - `beat_cnt` is $clog2(MAX_BURST+1) bits wide and never exceeds MAX_BURST-1.
  - `rr_ptr` is $clog2(NREQ) bits wide. For non-power-of-two NREQ, wrap explicitly; do not rely on overflow.
- **Error flag**
  - `err_burst` is set by a forced release and cleared by `err_clr`.
  - Set wins when both occur in the same cycle.
- **Reset values**
  - State IDLE; `rr_ptr` = 0; `grant_id` = 0; `beat_cnt` = 0; `err_burst` = 0.
  - Combinational outputs `req_ready`, `w_en`, and `busy` are therefore 0.
  - `w_data` is `req_data[0]`.
- **Reset mid-burst**: the packet is abandoned and the next grant starts from source 0. FIFO contents are untouched (the FIFO has its own reset), so a partial packet may remain in it. Downstream framing must tolerate this.

## Timing
- **Arbitration latency**: `req_valid` rising in IDLE during cycle n gives `busy` and `req_ready` high in cycle n+1. The first word is written at the wclk edge ending cycle n+1.
- **Throughput**: one word per cycle while `w_full` is low.
- **Packet gap**: exactly one IDLE cycle between the last word of one packet and the first word of the next.
- **Full handling**: when `w_full` is high, `req_ready` and `w_en` drop in the same cycle. There is no registered path from `w_full` to `w_en`, because the FIFO's full flag already looks ahead one word.
- **State-change timing**: `grant_id`, `rr_ptr`, and `err_burst` change only on wclk edges. `busy` follows the state register.

## Test plan
- **Single source**: source 2 sends a 3-word packet 0xA0, 0xA1, 0xA2 (last on the third), FIFO never full. Required: `w_en` high for 3 consecutive cycles starting 1 cycle after valid; `w_data` in order; `grant_id` = 2; back to IDLE; `rr_ptr` = 3.
- **Round robin**: all 4 sources hold 1-word packets continuously from reset. Required: grants in order 0, 1, 2, 3, 0, each separated by one IDLE cycle; no source served twice before the others.
- **Backpressure**: `w_full` high for 3 cycles in the middle of a 4-word packet. Required: `w_en` and `req_ready` low for exactly those cycles; all 4 words written once, in order; no duplicates or drops.
- **Watchdog**: MAX_BURST = 16, source 1 sends 20 words and never asserts last. Required: 16 words accepted; forced IDLE; `err_burst` = 1; next grant goes to source 2 if valid. `err_clr` together with a new overflow in the same cycle leaves `err_burst` = 1.
- **Idle grant hold**: granted source drops valid for 10 cycles mid-packet while source 3 is valid. Required: no writes, `grant_id` unchanged, source 3 never ready until the granted source's last word.
- **Async reset mid-burst**: assert `wrst_n` low after 2 of 4 words. Required: `w_en`, `req_ready`, `busy`, and `err_burst` go to 0 immediately; after release, the first grant goes to the lowest-index valid source.
